// File: rtl/recording_sequencer.sv
// Records key runs as {key,dur} RAM entries and replays them. Writes land one cycle after a tick; reads take a 2-cycle fetch gap.
// No backpressure: the RAM accepts one access per cycle, and start/stop are single-cycle pulses.
module recording_sequencer #(
    parameter int TICK_CYCLES = 500000,
    parameter int ADDR_W      = 10,
    parameter int DUR_W       = 10
) (
    input  logic                clock_50Mhz,
    input  logic                reset,
    input  logic                start_record,
    input  logic                start_play,
    input  logic                stop,
    input  logic [5:0]          input_MusicKey,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic                mem_re,
    output logic [6+DUR_W-1:0]  mem_wdata,
    input  logic [6+DUR_W-1:0]  mem_rdata,
    output logic [5:0]          play_key,
    output logic                play_valid,
    output logic [ADDR_W:0]     rec_length,
    output logic                busy,
    output logic                done
);

    localparam int TCW = $clog2(TICK_CYCLES + 1);
    localparam logic [DUR_W-1:0]  MAX_DUR   = '1;
    localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
    localparam logic [ADDR_W:0]   DEPTH     = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        IDLE, REC, REC_FLUSH, PLAY_FETCH, PLAY_WAIT, PLAY_HOLD
    } state_t;

    state_t             state;
    logic [TCW-1:0]     tick_cnt;
    logic               tick;
    logic [5:0]         cur_key;
    logic [DUR_W-1:0]   dur;
    logic [DUR_W-1:0]   remaining;
    logic [ADDR_W-1:0]  wr_addr;
    logic [ADDR_W-1:0]  rd_addr;

    assign tick = (state == REC || state == PLAY_HOLD) && (tick_cnt == TCW'(TICK_CYCLES - 1));
    assign busy = (state != IDLE);

    always_ff @(posedge clock_50Mhz) begin
        if (reset) begin
            state      <= IDLE;
            tick_cnt   <= '0;
            cur_key    <= '0;
            dur        <= '0;
            remaining  <= '0;
            wr_addr    <= '0;
            rd_addr    <= '0;
            mem_addr   <= '0;
            mem_we     <= 1'b0;
            mem_re     <= 1'b0;
            mem_wdata  <= '0;
            play_key   <= '0;
            play_valid <= 1'b0;
            rec_length <= '0;
            done       <= 1'b0;
        end else begin
            mem_we <= 1'b0;
            mem_re <= 1'b0;
            done   <= 1'b0;
            // Counter only runs in the two timed states, so any other state clears it for the next entry
            tick_cnt <= ((state == REC || state == PLAY_HOLD) && !tick) ? tick_cnt + 1'b1 : '0;

            case (state)
                IDLE: begin
                    if (start_record) begin
                        wr_addr    <= '0;
                        dur        <= '0;
                        rec_length <= '0;
                        state      <= REC;
                    end else if (start_play) begin
                        if (rec_length == '0) begin
                            done <= 1'b1;
                        end else begin
                            rd_addr  <= '0;
                            mem_re   <= 1'b1;
                            mem_addr <= '0;
                            state    <= PLAY_FETCH;
                        end
                    end
                end
                REC: begin
                    if (stop) begin
                        if (dur != '0) begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr;
                            mem_wdata <= {cur_key, dur};
                            state     <= REC_FLUSH;
                        end else begin
                            rec_length <= {1'b0, wr_addr};
                            done       <= 1'b1;
                            state      <= IDLE;
                        end
                    end else if (tick) begin
                        if (dur == '0) begin
                            cur_key <= input_MusicKey;
                            dur     <= DUR_W'(1);
                        end else if (input_MusicKey == cur_key && dur != MAX_DUR) begin
                            dur <= dur + 1'b1;
                        end else begin
                            mem_we    <= 1'b1;
                            mem_addr  <= wr_addr;
                            mem_wdata <= {cur_key, dur};
                            wr_addr   <= wr_addr + 1'b1;
                            cur_key   <= input_MusicKey;
                            dur       <= DUR_W'(1);
                            // Last slot filled: finish alongside the write, dropping the new key
                            if (wr_addr == LAST_ADDR) begin
                                rec_length <= DEPTH;
                                done       <= 1'b1;
                                state      <= IDLE;
                            end
                        end
                    end
                end
                REC_FLUSH: begin
                    rec_length <= {1'b0, wr_addr} + 1'b1;
                    done       <= 1'b1;
                    state      <= IDLE;
                end
                PLAY_FETCH, PLAY_WAIT, PLAY_HOLD: begin
                    if (stop) begin
                        play_valid <= 1'b0;
                        play_key   <= '0;
                        done       <= 1'b1;
                        state      <= IDLE;
                    end else if (state == PLAY_FETCH) begin
                        state <= PLAY_WAIT;
                    end else if (state == PLAY_WAIT) begin
                        play_key   <= mem_rdata[6+DUR_W-1:DUR_W];
                        remaining  <= (mem_rdata[DUR_W-1:0] == '0) ? DUR_W'(1) : mem_rdata[DUR_W-1:0];
                        play_valid <= 1'b1;
                        state      <= PLAY_HOLD;
                    end else if (tick) begin
                        if (remaining == DUR_W'(1)) begin
                            if ({1'b0, rd_addr} == rec_length - 1'b1) begin
                                play_valid <= 1'b0;
                                play_key   <= '0;
                                done       <= 1'b1;
                                state      <= IDLE;
                            end else begin
                                rd_addr  <= rd_addr + 1'b1;
                                mem_re   <= 1'b1;
                                mem_addr <= rd_addr + 1'b1;
                                state    <= PLAY_FETCH;
                            end
                        end else begin
                            remaining <= remaining - 1'b1;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
